hiz_tile_max_reducer: RTL and testbench

//  Recomputes the farthest (max) depth of one Hi-Z tile from the leaf depth buffer after early-Z commits.

---
 rtl/hiz_tile_max_reducer.sv | 108 ++++++++++
 tb/tb_hiz_tile_max_reducer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hiz_tile_max_reducer.sv
// Hi-Z tile max reducer: streams every leaf depth sample of one tile
// through a fixed-latency read port and emits the farthest (max) depth.
module hiz_tile_max_reducer #(
   parameter int DEPTH_BITS   = 24,
   parameter int TILE_ID_BITS = 10,
   parameter int SAMPLES_LOG2 = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 req_valid,
   output logic                                 req_ready,
   input  logic [TILE_ID_BITS-1:0]              req_tile_id,
   output logic                                 rd_en,
   output logic [TILE_ID_BITS+SAMPLES_LOG2-1:0] rd_addr,
   input  logic [DEPTH_BITS-1:0]                rd_data,
   output logic                                 upd_valid,
   input  logic                                 upd_ready,
   output logic [TILE_ID_BITS-1:0]              upd_tile_id,
   output logic [DEPTH_BITS-1:0]                upd_max_z,
   output logic                                 busy
);

   localparam logic [SAMPLES_LOG2-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      OUTPUT
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [TILE_ID_BITS-1:0]  tile_q;
   logic [SAMPLES_LOG2-1:0]  issue_idx;
   logic [SAMPLES_LOG2-1:0]  recv_cnt;
   logic [DEPTH_BITS-1:0]    acc;
   logic [DEPTH_BITS-1:0]    acc_nxt;
   logic                     rd_pend;
   logic                     accept;
   logic                     ret_last;

   // rd_pend marks the cycle in which rd_data belongs to this reduction
   assign accept   = req_valid && req_ready;
   assign ret_last = rd_pend && (recv_cnt == LAST_IDX);
   assign acc_nxt  = (rd_data > acc) ? rd_data : acc;
   assign rd_addr  = {tile_q, issue_idx};

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rd_en     = 1'b0;
      upd_valid = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            rd_en = 1'b1;
            if (issue_idx == LAST_IDX) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (ret_last) state_nxt = OUTPUT;
         end
         OUTPUT: begin
            upd_valid = 1'b1;
            if (upd_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tile_q      <= '0;
         issue_idx   <= '0;
         recv_cnt    <= '0;
         acc         <= '0;
         rd_pend     <= 1'b0;
         upd_tile_id <= '0;
         upd_max_z   <= '0;
      end else begin
         state   <= state_nxt;
         rd_pend <= rd_en;
         if (accept) begin
            tile_q    <= req_tile_id;
            issue_idx <= '0;
            recv_cnt  <= '0;
            acc       <= '0;
         end
         if (rd_en) issue_idx <= issue_idx + 1'b1;
         if (rd_pend) begin
            acc      <= acc_nxt;
            recv_cnt <= recv_cnt + 1'b1;
         end
         // result regs stay put across the next tile's accumulation
         if (ret_last) begin
            upd_tile_id <= tile_q;
            upd_max_z   <= acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_hiz_tile_max_reducer.sv
// Directed bench for hiz_tile_max_reducer with a one-cycle-latency
// leaf depth memory model.
module tb_hiz_tile_max_reducer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_tile_id;
   logic        rd_en;
   logic [13:0] rd_addr;
   logic [23:0] rd_data;
   logic        upd_valid;
   logic        upd_ready;
   logic [9:0]  upd_tile_id;
   logic [23:0] upd_max_z;
   logic        busy;

   logic [23:0] mem [16];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          upd_cnt = 0;
   int          acc_cyc [$];
   logic [33:0] upd_q [$];

   always #5 clk = ~clk;

   hiz_tile_max_reducer dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_tile_id (req_tile_id),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .upd_valid   (upd_valid),
      .upd_ready   (upd_ready),
      .upd_tile_id (upd_tile_id),
      .upd_max_z   (upd_max_z),
      .busy        (busy)
   );

   // leaf memory: data one cycle after rd_en, junk otherwise
   always @(posedge clk) begin
      cyc <= cyc + 1;
      rd_data <= rd_en ? mem[rd_addr[3:0]] : 24'hFFFFFF;
   end

   always @(negedge clk) begin
      if (req_valid && req_ready) acc_cyc.push_back(cyc);
      if (upd_valid && upd_ready) begin
         upd_cnt++;
         upd_q.push_back({upd_tile_id, upd_max_z});
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rst_vec();
      return {req_ready, rd_en, rd_addr, upd_valid, upd_tile_id,
              upd_max_z, busy};
   endfunction

   // full reduction from IDLE; leaves the bench at a negedge in IDLE
   task automatic run_tile(input string tag, input logic [9:0] tile,
                           input logic [23:0] exp_max, input int hold);
      bit          ok = 1'b1;
      logic [13:0] last_addr = '0;
      upd_ready   = (hold == 0);
      req_tile_id = tile;
      req_valid   = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (rd_en !== 1'b1 || rd_addr !== {tile, k[3:0]}) ok = 1'b0;
         if (upd_valid !== 1'b0 || req_ready !== 1'b0) ok = 1'b0;
         last_addr = rd_addr;
         @(negedge clk);
      end
      if (rd_en !== 1'b0 || upd_valid !== 1'b0) ok = 1'b0;
      chk({tag, "_issue_seq"}, 64'(ok), 64'd1);
      chk({tag, "_last_addr"}, 64'(last_addr), 64'({tile, 4'hF}));
      @(negedge clk);
      chk({tag, "_lat18"}, 64'(upd_valid), 64'd1);
      chk({tag, "_result"}, 64'({upd_tile_id, upd_max_z}),
          64'({tile, exp_max}));
      if (hold > 0) begin
         ok = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (upd_valid !== 1'b1 || req_ready !== 1'b0) ok = 1'b0;
            if ({upd_tile_id, upd_max_z} !== {tile, exp_max}) ok = 1'b0;
         end
         chk({tag, "_hold"}, 64'(ok), 64'd1);
         upd_ready = 1'b1;
      end
      @(negedge clk);
      chk({tag, "_idle"}, 64'({req_ready, busy, upd_valid}), 64'b100);
      chk({tag, "_kept"}, 64'({upd_tile_id, upd_max_z}),
          64'({tile, exp_max}));
   endtask

   initial begin
      int          n;
      int          u0;
      logic [9:0]  ids [3];
      rst         = 1'b1;
      req_valid   = 1'b0;
      req_tile_id = '0;
      upd_ready   = 1'b1;
      for (int k = 0; k < 16; k++) mem[k] = '0;
      @(negedge clk);
      @(negedge clk);
      chk("reset", rst_vec(), {1'b1, 1'b0, 14'h0, 1'b0, 10'h0, 24'h0, 1'b0});
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 16; k++) mem[k] = 24'(k * 24'h1000);
      mem[9] = 24'hABCDEF;
      run_tile("t1", 10'd5, 24'hABCDEF, 0);

      for (int k = 0; k < 16; k++) mem[k] = 24'h0;
      run_tile("t2_zero", 10'd0, 24'h0, 0);
      for (int k = 0; k < 16; k++) mem[k] = 24'hFFFFFF;
      run_tile("t2_full", 10'd3, 24'hFFFFFF, 0);

      for (int k = 0; k < 16; k++) mem[k] = 24'(k * 24'h11);
      run_tile("t3", 10'd4, 24'h0000FF, 10);

      // abort tile 6 on its 7th read cycle
      for (int k = 0; k < 16; k++) mem[k] = 24'hFFFFFF;
      u0          = upd_cnt;
      req_tile_id = 10'd6;
      req_valid   = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("t4_7th", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd6, 4'd6}));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_rst", rst_vec(), {1'b1, 1'b0, 14'h0, 1'b0, 10'h0, 24'h0, 1'b0});
      for (int k = 0; k < 16; k++) mem[k] = 24'(k + 24'h100);
      run_tile("t4_new", 10'd2, 24'h00010F, 0);
      chk("t4_upds", 64'(upd_cnt - u0), 64'd1);

      for (int k = 0; k < 16; k++) mem[k] = 24'h7FFFFF;
      mem[15] = 24'h800000;
      run_tile("t5", 10'd1023, 24'h800000, 0);

      for (int k = 0; k < 16; k++) mem[k] = 24'(k * 3);
      upd_q.delete();
      acc_cyc.delete();
      ids[0]      = 10'd7;
      ids[1]      = 10'd8;
      ids[2]      = 10'd9;
      req_tile_id = ids[0];
      req_valid   = 1'b1;
      n           = 1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (req_ready && n < 3) begin
            req_tile_id = ids[n];
            n++;
         end else if (n == 3 && !req_ready) begin
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("t6_accepts", 64'(acc_cyc.size()), 64'd3);
      chk("t6_upds", 64'(upd_q.size()), 64'd3);
      if (acc_cyc.size() == 3) begin
         chk("t6_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd19);
         chk("t6_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd19);
      end
      for (int i = 0; i < 3; i++) begin
         if (i < upd_q.size())
            chk($sformatf("t6_upd%0d", i), 64'(upd_q[i]),
                64'({ids[i], 24'h00002D}));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
